// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined channel selector (mux_pipe).
// Holds the default geometry, the error-counter width used when
// MUX_ERR_CNT_EN is defined, and the select range-check helper.
package mux_pkg;

    localparam int MUX_N_DEF     = 31;
    localparam int MUX_W_DEF     = 2;
    localparam int MUX_SEL_W_DEF = 5;
    localparam int MUX_ERR_CNT_W = 8;

    // True when the select names an existing channel (sel < n).
    function automatic logic sel_in_range(input logic [31:0] sel, input logic [31:0] n);
        return (sel < n);
    endfunction

endpackage

// File: rtl/mux_sel_core.sv
// Combinational N:1, W-bit channel selector with a range check.
// Out-of-range selects return zero data and raise err.
module mux_sel_core
    import mux_pkg::*;
#(
    parameter int N     = MUX_N_DEF,
    parameter int W     = MUX_W_DEF,
    parameter int SEL_W = MUX_SEL_W_DEF
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [N*W-1:0]   inp,
    output logic [W-1:0]     data,
    output logic             err
);

    localparam int SLOTS = 2 ** SEL_W;

    // One slot per encodable select value; slots past N read as zero so the
    // array can be indexed by the full select without any width adaptation.
    logic [W-1:0] ch_s [SLOTS];

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        if (k < N) begin : g_live
            assign ch_s[k] = inp[k*W +: W];
        end else begin : g_pad
            assign ch_s[k] = '0;
        end
    end

    // Pick the addressed channel, or flag the select as out of range.
    always_comb begin
        data = '0;
        err  = 1'b0;
        if (sel_in_range(32'(sel), 32'(N))) begin
            data = ch_s[sel];
            err  = 1'b0;
        end else begin
            data = '0;
            err  = 1'b1;
        end
    end

endmodule

// File: rtl/mux_pipe.sv
// Pipelined N-input, W-bit channel selector with valid/ready handshake on
// both sides and a single registered result stage (1-cycle latency, full
// throughput, no bubble on simultaneous drain and accept).
// Out-of-range selects produce zero data with out_err set and raise the
// sticky error flag. Optional macro MUX_ERR_CNT_EN adds a saturating 8-bit
// error counter on output err_cnt.
module mux_pipe
    import mux_pkg::*;
#(
    parameter int N     = MUX_N_DEF,
    parameter int W     = MUX_W_DEF,
    parameter int SEL_W = MUX_SEL_W_DEF
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N*W-1:0]           inp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic                     out_err,
    output logic                     err_sticky,
    input  logic                     err_clr
`ifdef MUX_ERR_CNT_EN
    ,
    output logic [MUX_ERR_CNT_W-1:0] err_cnt
`endif
);

    // Geometry checks at elaboration.
    if (N < 2 || N > 256) begin : g_bad_n
        $error("mux_pipe: N must lie in 2..256");
    end
    if (W < 1 || W > 64) begin : g_bad_w
        $error("mux_pipe: W must lie in 1..64");
    end
    if (N > 2 ** SEL_W) begin : g_bad_sel_w
        $error("mux_pipe: SEL_W too narrow for N channels");
    end

    logic [W-1:0] core_data_s;
    logic         core_err_s;
    logic         accept_s;
    logic         err_set_s;

    mux_sel_core #(
        .N     (N),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_core (
        .sel  (sel),
        .inp  (inp),
        .data (core_data_s),
        .err  (core_err_s)
    );

    // The stage is free when empty or being drained this cycle.
    assign in_ready  = !out_valid || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign err_set_s = accept_s && core_err_s;

    // Result stage: load on accept, drop valid on drain, otherwise hold.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_data  <= core_data_s;
            out_err   <= core_err_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= out_data;
            out_err   <= out_err;
        end else begin
            out_valid <= out_valid;
            out_data  <= out_data;
            out_err   <= out_err;
        end
    end

    // Sticky error flag: a new error wins over a clear in the same cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err_sticky <= 1'b0;
        end else if (err_set_s) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end else begin
            err_sticky <= err_sticky;
        end
    end

`ifdef MUX_ERR_CNT_EN
    // Saturating error counter; an increment alongside a clear leaves 1.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err_cnt <= '0;
        end else if (err_set_s) begin
            if (err_clr) begin
                err_cnt <= MUX_ERR_CNT_W'(1);
            end else if (err_cnt != {MUX_ERR_CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + MUX_ERR_CNT_W'(1);
            end else begin
                err_cnt <= err_cnt;
            end
        end else if (err_clr) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= err_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_mux_pipe.sv
// Directed self-checking bench for mux_pipe (N=31, W=2, SEL_W=5).
// Expected results are pushed to a scoreboard queue on accept and compared
// while the result is presented; handshake and error state are modelled
// alongside. The counter section is built when MUX_ERR_CNT_EN is defined.
module tb_mux_pipe;

    localparam int N     = 31;
    localparam int W     = 2;
    localparam int SEL_W = 5;

    logic             CLK;
    logic             RST_N;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic [N*W-1:0]   inp;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_err;
    logic             err_sticky;
    logic             err_clr;
`ifdef MUX_ERR_CNT_EN
    logic [7:0]       err_cnt;
`endif

    mux_pipe #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .inp        (inp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
`ifdef MUX_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         n_vec = 0;
    int         n_err = 0;
    logic [2:0] sb[$];      // {err, data[1:0]}
    logic       m_ov  = 1'b0;
    logic       m_st  = 1'b0;
    int         m_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference selection: channel data for sel<N, else zero with error set.
    function automatic logic [2:0] mdl(input logic [SEL_W-1:0] s, input logic [N*W-1:0] v);
        int si;
        si = int'(s);
        if (si < N) return {1'b0, v[si*W +: W]};
        else        return 3'b100;
    endfunction

    // One clock: check handshake before the edge, then update model and compare.
    task automatic tick();
        logic acc;
        logic drn;
        logic e;
        #1;
        if (RST_N) chk("in_ready", 64'(in_ready), 64'(!m_ov || out_ready));
        acc = RST_N && in_valid && (!m_ov || out_ready);
        drn = RST_N && m_ov && out_ready;
        e   = mdl(sel, inp) >> 2;
        if (acc) sb.push_back(mdl(sel, inp));
        @(posedge CLK);
        #1;
        if (!RST_N) begin
            m_ov = 1'b0; m_st = 1'b0; m_cnt = 0;
            sb.delete();
        end else begin
            if (drn && sb.size() > 0 && !(acc && sb.size() == 1)) void'(sb.pop_front());
            else if (drn && acc && sb.size() == 2) void'(sb.pop_front());
            m_ov = acc ? 1'b1 : (drn ? 1'b0 : m_ov);
            if (acc && e)      m_st = 1'b1;
            else if (err_clr)  m_st = 1'b0;
            if (acc && e)      m_cnt = err_clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
            else if (err_clr)  m_cnt = 0;
        end
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov && sb.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(sb[0][1:0]));
            chk("out_err", 64'(out_err), 64'(sb[0][2]));
        end
        chk("err_sticky", 64'(err_sticky), 64'(m_st));
`ifdef MUX_ERR_CNT_EN
        chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
`endif
    endtask

    initial begin
        logic [N*W-1:0] ramp;
        for (int k = 0; k < N; k++) ramp[k*W +: W] = W'(k % 4);

        // Reset held for three cycles, then idle.
        RST_N = 1'b0; in_valid = 1'b0; sel = '0; inp = '0;
        out_ready = 1'b1; err_clr = 1'b0;
        repeat (3) tick();
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_err", 64'(out_err), 64'(0));
        RST_N = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'(1));

        // Back-to-back sweep of all legal selects.
        inp = ramp; in_valid = 1'b1;
        for (int s = 0; s < N; s++) begin
            sel = SEL_W'(s);
            tick();
            chk("sweep_k_mod_4", 64'(out_data), 64'(s % 4));
            chk("sweep_no_bubble", 64'(out_valid), 64'(1));
        end

        // First out-of-range value, then a legal one: sticky persists.
        sel = 5'd31; tick();
        chk("oor_err", 64'(out_err), 64'(1));
        chk("oor_data", 64'(out_data), 64'(0));
        chk("oor_sticky", 64'(err_sticky), 64'(1));
        sel = 5'd3; tick();
        chk("after_oor_err", 64'(out_err), 64'(0));
        chk("after_oor_sticky", 64'(err_sticky), 64'(1));

        // Back-pressure: result sampled for sel=5 must hold while stalled.
        sel = 5'd5; tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inp = {$urandom, $urandom};
            sel = SEL_W'($urandom_range(0, 30));
            tick();
            chk("hold_data", 64'(out_data), 64'(1));
            chk("hold_in_ready", 64'(in_ready), 64'(0));
        end
        inp = ramp; sel = 5'd6; out_ready = 1'b1;
        tick();
        chk("release_accept", 64'(out_data), 64'(2));

        // Set wins over clear; clear alone then drops the flag.
        sel = 5'd31; err_clr = 1'b1; tick();
        chk("clr_vs_set", 64'(err_sticky), 64'(1));
        in_valid = 1'b0; tick();
        chk("clr_alone", 64'(err_sticky), 64'(0));
        err_clr = 1'b0;

        // Reset while a result is stalled.
        in_valid = 1'b1; sel = 5'd2; tick();
        out_ready = 1'b0; in_valid = 1'b0; tick();
        RST_N = 1'b0; tick();
        chk("midrst_valid", 64'(out_valid), 64'(0));
        RST_N = 1'b1; out_ready = 1'b1; tick();

        // Mixed random traffic against the scoreboard.
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            err_clr   = 1'($urandom_range(0, 7) == 0);
            sel       = SEL_W'($urandom);
            inp       = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        tick();

`ifdef MUX_ERR_CNT_EN
        // Counter saturation, increment-over-clear, and reset.
        in_valid = 1'b1; sel = 5'd31;
        repeat (300) tick();
        chk("cnt_sat", 64'(err_cnt), 64'(255));
        err_clr = 1'b1; tick();
        chk("cnt_inc_over_clr", 64'(err_cnt), 64'(1));
        err_clr = 1'b0; tick();
        RST_N = 1'b0; tick();
        chk("cnt_rst", 64'(err_cnt), 64'(0));
        RST_N = 1'b1; in_valid = 1'b0; tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_pipe.md
Name: mux_pipe

Overview:
- Parametrised N-input, W-bit selector with a registered output stage and valid/ready handshake on both sides.
- Next generation of the 31:1 2-bit combinational selector.
- Every select value has defined behaviour: out-of-range selects are flagged and reported, never silently zeroed.
- Sits between the sampling logic and downstream consumers. Makes the select path timing-clean and back-pressurable.

Parameters:
- N, 31, number of input channels (2..256).
- W, 2, data width per channel (1..64).
- SEL_W, 5, select width; N <= 2**SEL_W is required, checked at elaboration.

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- in_valid  input  1  request valid; sel and inp are sampled when in_valid && in_ready.
- in_ready  output  1  stage can accept; equals !out_valid || out_ready.
- sel  input  SEL_W  channel index.
- inp  input  N*W  packed channel data; channel k occupies bits [k*W +: W].
- out_valid  output  1  out_data/out_err hold a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  W  selected channel, or 0 if out of range.
- out_err  output  1  this result had sel >= N.
- err_sticky  output  1  set by any accepted out-of-range select; held until cleared.
- err_clr  input  1  clears err_sticky.

Behaviour:
- Reset (RST_N low at a rising CLK edge): out_valid=0, out_data=0, out_err=0, err_sticky=0. Any pending result is dropped. in_ready is 1 the cycle after reset deasserts.
- Accept = in_valid && in_ready.
- On accept, at the next edge:
  - out_valid<=1.
  - out_data<=inp[sel*W +: W] if sel<N, else 0.
  - out_err<=(sel>=N).
- Latency: 1 cycle, input accept to out_valid. Throughput: 1 per cycle while out_ready=1.
- Hold: out_valid && !out_ready keeps out_data/out_err stable. in_ready=0. in_valid is ignored.
- Drain: out_valid && out_ready && !accept -> out_valid<=0. out_data keeps its last value.
- Simultaneous drain and accept: the new result replaces the old one in the same edge. No bubble.
- err_sticky:
  - Set on accept with sel>=N.
  - Cleared by err_clr=1 when no set occurs in the same cycle; set wins over clear.
  - Independent of the handshake.
- Boundaries:
  - sel=N-1 selects the top channel.
  - sel=N is the first error value.
  - When N==2**SEL_W, no error is possible; out_err and err_sticky stay 0.
- inp changes after accept do not affect a held result.
- No combinational path from in_valid/sel/inp to any output. in_ready depends combinationally only on out_valid and out_ready.

Optional Feature:
- MUX_ERR_CNT_EN defined:
  - Adds output err_cnt [7:0].
  - err_cnt counts accepted out-of-range selects and saturates at 255.
  - err_clr also zeroes err_cnt; an increment in the same cycle wins, so err_cnt becomes 1.
  - Reset value is 0.
- MUX_ERR_CNT_EN undefined: port absent, no counter logic.

Decomposition:
- Shared package mux_pkg:
  - default N/W/SEL_W localparams;
  - a function sel_in_range(sel, n);
  - a constant MUX_ERR_CNT_W=8.
- Sub-module mux_sel_core: combinational N:1 W-bit selector with range check. Outputs data and err.
- mux_pipe instantiates one mux_sel_core plus the register stage, handshake and error logic.

Test Plan:
- Reset then idle: hold RST_N=0 for 3 cycles -> out_valid=0, out_data=0, err_sticky=0, in_ready=1.
- Sweep (N=31, W=2), with inp[k]=k%4 and out_ready=1:
  - stream sel=0..30 back-to-back -> out_data=k%4 one cycle later for each, out_err=0, no bubbles;
  - sel=12 and sel=14 return distinct channels.
- Out-of-range: sel=31 accepted -> out_data=0, out_err=1, err_sticky=1. Then sel=3 -> out_err=0 while err_sticky stays 1.
- Back-pressure:
  - accept sel=5, then hold out_ready=0 for 4 cycles while changing inp and sel -> out_data stays the sampled value, in_ready=0;
  - release -> next request is accepted in the same cycle.
- Clear priority: err_clr=1 in the same cycle as an accepted sel=31 -> err_sticky=1. err_clr alone next cycle -> err_sticky=0.
- Mid-operation reset: RST_N=0 while out_valid=1 and out_ready=0 -> out_valid=0 next edge. With MUX_ERR_CNT_EN: 300 errors -> err_cnt=255, and reset -> 0.
